// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arb
//  Purpose  : Round-robin scheduler sharing one UART transmitter among N_REQ
//             byte sources. A granted requester keeps the transmitter for a
//             whole packet (closed by its last flag). Every byte handoff is
//             sequenced against the UART tx_busy status.
//  Ports    : clk, rstn       - clock, synchronous active-low reset
//             req/data/last   - per-requester byte valid, byte, end-of-packet
//             ack             - one-cycle capture pulse to the served requester
//             tx_data/tx_req  - byte and start pulse to the UART transmitter
//             tx_busy         - UART transmitter busy status
//             grant_v/owner   - lock held flag and lock holder index
//             to_irq          - one-cycle forced-release pulse
//  Options  : UART_ARB_TIMEOUT_EN - enables the idle-lock timeout (TIMEOUT
//             consecutive GRANT cycles without req[owner] force a release).
//             Undefined: the lock is held indefinitely and to_irq is tied 0.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
    parameter int N_REQ   = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DW-1:0]      data,
    input  logic [N_REQ-1:0]         last,
    output logic [N_REQ-1:0]         ack,
    output logic [DW-1:0]            tx_data,
    output logic                     tx_req,
    input  logic                     tx_busy,
    output logic                     grant_v,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     to_irq
);

    localparam int OW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_END   = 2'd3
    } state_t;

    if (N_REQ < 2 || N_REQ > 8 || DW < 1 || TIMEOUT < 1) begin : g_param_check
        $error("uart_tx_arb: parameter out of range");
    end

    // Per-requester byte view so the owner index selects a whole byte.
    logic [DW-1:0] data_arr [N_REQ];
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign data_arr[gi] = data[gi*DW +: DW];
    end

    state_t            state_q, state_d;
    logic [OW-1:0]     rr_q, rr_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic              grant_v_q, grant_v_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [DW-1:0]     tx_data_q, tx_data_d;
    logic              tx_req_q, tx_req_d;
    logic              last_q, last_d;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              to_irq_q, to_irq_d;
`endif

    // Round-robin pick: scan downward in distance from rr so the nearest
    // requester after rr is the last (winning) assignment.
    logic [OW-1:0] pick;
    logic [OW-1:0] cand;
    always_comb begin
        pick = '0;
        cand = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = OW'((int'(rr_q) + i) % N_REQ);
            if (req[cand]) begin
                pick = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        grant_v_d = grant_v_q;
        tx_data_d = tx_data_q;
        last_d    = last_q;
        ack_d     = '0;
        tx_req_d  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        to_irq_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // A busy UART (e.g. still shifting across a reset) blocks grants.
                if (!tx_busy && (|req)) begin
                    owner_d   = pick;
                    grant_v_d = 1'b1;
                    state_d   = GRANT;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            GRANT: begin
                if (req[owner_q]) begin
                    tx_data_d      = data_arr[owner_q];
                    tx_req_d       = 1'b1;
                    ack_d[owner_q] = 1'b1;
                    last_d         = last[owner_q];
                    state_d        = WAIT_START;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d          = '0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th idle GRANT cycle: force release.
                    to_irq_d  = 1'b1;
                    grant_v_d = 1'b0;
                    rr_d      = owner_q;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d     = cnt_q + CW'(1);
`endif
                end
            end
            WAIT_START: begin
                if (tx_busy) begin
                    state_d = WAIT_END;
                end
            end
            WAIT_END: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        rr_d      = owner_q;
                        grant_v_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        state_d   = GRANT;
`ifdef UART_ARB_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            rr_q      <= OW'(N_REQ - 1);
            owner_q   <= '0;
            grant_v_q <= 1'b0;
            ack_q     <= '0;
            tx_data_q <= '0;
            tx_req_q  <= 1'b0;
            last_q    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            to_irq_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            grant_v_q <= grant_v_d;
            ack_q     <= ack_d;
            tx_data_q <= tx_data_d;
            tx_req_q  <= tx_req_d;
            last_q    <= last_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            to_irq_q  <= to_irq_d;
`endif
        end
    end

    assign ack     = ack_q;
    assign tx_data = tx_data_q;
    assign tx_req  = tx_req_q;
    assign grant_v = grant_v_q;
    assign owner   = owner_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign to_irq  = to_irq_q;
`else
    assign to_irq  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arb
//  Purpose  : Directed self-checking bench for uart_tx_arb (N_REQ=4, DW=8,
//             TIMEOUT=16) with a simple UART model holding tx_busy for 10
//             cycles after every tx_req.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  req  = '0;
    logic [31:0] data = '0;
    logic [3:0]  last = '0;
    logic [3:0]  ack;
    logic [7:0]  tx_data;
    logic        tx_req;
    logic        tx_busy;
    logic        grant_v;
    logic [1:0]  owner;
    logic        to_irq;

    int   checks     = 0;
    int   errors     = 0;
    int   busy_cnt   = 0;
    logic busy_force = 1'b0;

    always #5 clk = ~clk;

    // UART model: busy for 10 cycles starting the edge after tx_req.
    always @(posedge clk) begin
        if (tx_req) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0) || busy_force;

    uart_tx_arb #(.N_REQ(4), .DW(8), .TIMEOUT(16)) dut (
        .clk(clk), .rstn(rstn), .req(req), .data(data), .last(last),
        .ack(ack), .tx_data(tx_data), .tx_req(tx_req), .tx_busy(tx_busy),
        .grant_v(grant_v), .owner(owner), .to_irq(to_irq)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_txreq(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (tx_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (!grant_v && !tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        tick(); tick();
        checks++; if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
        checks++; if (tx_req !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx got req=%b data=%h want 0/00", tx_req, tx_data); end
        checks++; if (grant_v !== 1'b0 || owner !== 2'd0 || to_irq !== 1'b0) begin errors++; $display("FAIL reset_grant got gv=%b own=%0d irq=%b want 0/0/0", grant_v, owner, to_irq); end
        rstn = 1'b1;
    endtask

    task automatic test_single;
        int n;
        bit ok;
        req = 4'b0001; data = 32'h0000_00A5; last = 4'b0001;
        tick();
        checks++; if (grant_v !== 1'b1 || owner !== 2'd0 || tx_req !== 1'b0) begin errors++; $display("FAIL single_grant got gv=%b own=%0d txreq=%b want 1/0/0", grant_v, owner, tx_req); end
        tick();
        checks++; if (tx_req !== 1'b1 || ack !== 4'b0001 || tx_data !== 8'hA5) begin errors++; $display("FAIL single_tx got req=%b ack=%b data=%h want 1/0001/a5", tx_req, ack, tx_data); end
        req = 4'b0000;
        tick();
        checks++; if (ack !== 4'b0 || tx_req !== 1'b0) begin errors++; $display("FAIL single_pulse got ack=%b req=%b want 0000/0", ack, tx_req); end
        n = 1;
        while (grant_v && n < 40) begin tick(); n++; end
        checks++; if (n !== 12) begin errors++; $display("FAIL single_release got %0d cycles want 12", n); end
        wait_idle(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_idle got timeout want idle"); end
    endtask

    task automatic test_rr;
        int   exp_o [5] = '{0, 1, 2, 3, 0};
        logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [3:0] e;
        bit ok;
        rstn = 1'b0; tick(); rstn = 1'b1;
        req = 4'b1111; last = 4'b1111; data = 32'h4433_2211;
        for (int k = 0; k < 5; k++) begin
            wait_txreq(60, ok);
            if (k == 4) req = 4'b0000;
            e = 4'b0001 << exp_o[k];
            checks++; if (!ok) begin errors++; $display("FAIL rr_wait%0d got timeout want tx_req", k); end
            checks++; if (owner !== 2'(exp_o[k]) || ack !== e) begin errors++; $display("FAIL rr_order%0d got own=%0d ack=%b want %0d/%b", k, owner, ack, exp_o[k], e); end
            checks++; if (tx_data !== exp_d[exp_o[k]]) begin errors++; $display("FAIL rr_data%0d got %h want %h", k, tx_data, exp_d[exp_o[k]]); end
        end
        wait_idle(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_idle got timeout want idle"); end
    endtask

    task automatic test_packet;
        logic [7:0] bytes [3] = '{8'h11, 8'h22, 8'h33};
        bit ok;
        req = 4'b0100; last = 4'b0000; data = 32'h0011_7700;
        tick();
        checks++; if (grant_v !== 1'b1 || owner !== 2'd2) begin errors++; $display("FAIL pkt_grant got gv=%b own=%0d want 1/2", grant_v, owner); end
        req = 4'b0110; last = 4'b0010;
        for (int b = 0; b < 3; b++) begin
            wait_txreq(60, ok);
            checks++; if (!ok || ack !== 4'b0100 || tx_data !== bytes[b]) begin errors++; $display("FAIL pkt_byte%0d got ok=%b ack=%b data=%h want 1/0100/%h", b, ok, ack, tx_data, bytes[b]); end
            if (b < 2) data[23:16] = bytes[b+1];
            if (b == 1) last[2] = 1'b1;
            if (b == 2) req[2] = 1'b0;
        end
        wait_txreq(60, ok);
        checks++; if (!ok || ack !== 4'b0010 || owner !== 2'd1 || tx_data !== 8'h77) begin errors++; $display("FAIL pkt_next got ok=%b ack=%b own=%0d data=%h want 1/0010/1/77", ok, ack, owner, tx_data); end
        req = 4'b0000; last = 4'b0000;
        wait_idle(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pkt_idle got timeout want idle"); end
    endtask

    task automatic test_busy_reset;
        bit ok;
        rstn = 1'b0; busy_force = 1'b1;
        req = 4'b0010; last = 4'b0010; data = 32'h0000_5A00;
        tick();
        rstn = 1'b1;
        repeat (5) tick();
        checks++; if (grant_v !== 1'b0 || tx_req !== 1'b0) begin errors++; $display("FAIL busy_hold got gv=%b txreq=%b want 0/0", grant_v, tx_req); end
        busy_force = 1'b0;
        tick();
        checks++; if (grant_v !== 1'b1 || owner !== 2'd1) begin errors++; $display("FAIL busy_grant got gv=%b own=%0d want 1/1", grant_v, owner); end
        tick();
        checks++; if (tx_req !== 1'b1 || ack !== 4'b0010 || tx_data !== 8'h5A) begin errors++; $display("FAIL busy_tx got req=%b ack=%b data=%h want 1/0010/5a", tx_req, ack, tx_data); end
        req = 4'b0000;
        wait_idle(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_idle got timeout want idle"); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int n;
        req = 4'b1000; last = 4'b0000; data = 32'hC300_0000;
        wait_txreq(40, ok);
        checks++; if (!ok || owner !== 2'd3 || tx_data !== 8'hC3) begin errors++; $display("FAIL mid_first got ok=%b own=%0d data=%h want 1/3/c3", ok, owner, tx_data); end
        repeat (3) tick();
        checks++; if (tx_busy !== 1'b1 || grant_v !== 1'b1) begin errors++; $display("FAIL mid_wait got busy=%b gv=%b want 1/1", tx_busy, grant_v); end
        rstn = 1'b0; req = 4'b1001; last = 4'b1001; data = 32'hC300_00A7;
        tick();
        checks++; if (ack !== 4'b0 || tx_req !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL mid_rst_tx got ack=%b req=%b data=%h want 0000/0/00", ack, tx_req, tx_data); end
        checks++; if (grant_v !== 1'b0 || owner !== 2'd0 || to_irq !== 1'b0) begin errors++; $display("FAIL mid_rst_grant got gv=%b own=%0d irq=%b want 0/0/0", grant_v, owner, to_irq); end
        rstn = 1'b1;
        n = 0;
        while (!grant_v && n < 40) begin tick(); n++; end
        checks++; if (grant_v !== 1'b1 || owner !== 2'd0) begin errors++; $display("FAIL mid_regrant got gv=%b own=%0d want 1/0", grant_v, owner); end
        tick();
        checks++; if (tx_req !== 1'b1 || ack !== 4'b0001 || tx_data !== 8'hA7) begin errors++; $display("FAIL mid_tx got req=%b ack=%b data=%h want 1/0001/a7", tx_req, ack, tx_data); end
        req = 4'b0000; last = 4'b0000;
        wait_idle(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_idle got timeout want idle"); end
    endtask

    task automatic test_timeout;
        bit ok;
        int n;
        req = 4'b0001; last = 4'b0000; data = 32'h0000_00E1;
        wait_txreq(40, ok);
        checks++; if (!ok || owner !== 2'd0 || tx_data !== 8'hE1) begin errors++; $display("FAIL to_first got ok=%b own=%0d data=%h want 1/0/e1", ok, owner, tx_data); end
        req = 4'b1000; last = 4'b1000; data = 32'h3C00_0000;
        n = 0;
        while (!tx_busy && n < 20) begin tick(); n++; end
        n = 0;
        while (tx_busy && n < 20) begin tick(); n++; end
`ifdef UART_ARB_TIMEOUT_EN
        n = 0;
        while (!to_irq && n < 40) begin tick(); n++; end
        checks++; if (n !== 17 || grant_v !== 1'b0) begin errors++; $display("FAIL to_fire got %0d cycles gv=%b want 17/0", n, grant_v); end
        tick();
        checks++; if (to_irq !== 1'b0 || grant_v !== 1'b1 || owner !== 2'd3) begin errors++; $display("FAIL to_next got irq=%b gv=%b own=%0d want 0/1/3", to_irq, grant_v, owner); end
        tick();
        checks++; if (tx_req !== 1'b1 || ack !== 4'b1000 || tx_data !== 8'h3C) begin errors++; $display("FAIL to_tx got req=%b ack=%b data=%h want 1/1000/3c", tx_req, ack, tx_data); end
        req = 4'b0000;
`else
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (tx_req || to_irq) ok = 1'b1;
        end
        checks++; if (ok || grant_v !== 1'b1 || owner !== 2'd0) begin errors++; $display("FAIL hold_lock got activity=%b gv=%b own=%0d want 0/1/0", ok, grant_v, owner); end
        req = 4'b0000;
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_packet();
        test_busy_reset();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin scheduler that shares one UART transmitter among `N_REQ` requesters. It sits between the per-master byte sources (CPU bus bridge, DMA, debug channels) and the UART TX data/start inputs. A granted requester holds the transmitter for a whole packet, closed by its `last` flag. Every byte handoff is sequenced against the UART `tx_busy` status, and lock ownership is reported for the UART status register.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `DW`, default 8: data width per byte.
- `TIMEOUT`, default 255: lock-idle cycles before forced release; used only with `UART_ARB_TIMEOUT_EN`.
- `clk` input 1: single clock; all logic on rising edge.
- `rstn` input 1: reset is synchronous and active-low.
- `req` input N_REQ: per-requester byte valid.
- `data` input N_REQ*DW: requester i byte on `data[i*DW +: DW]`.
- `last` input N_REQ: byte presented by requester i closes its packet.
- `ack` output N_REQ: one-cycle pulse; the byte of that requester has been captured.
- `tx_data` output DW: byte to the UART transmitter.
- `tx_req` output 1: one-cycle start pulse to the UART transmitter.
- `tx_busy` input 1: UART transmitter busy (start bit through stop bit).
- `grant_v` output 1: a requester holds the lock.
- `owner` output $clog2(N_REQ): index of the lock holder; valid when `grant_v`=1.
- `to_irq` output 1: one-cycle pulse on forced release; constant 0 without the macro.

## Operation
- FSM states: IDLE, GRANT, WAIT_START, WAIT_END.
- IDLE:
  - If `tx_busy`=0 and any `req` is high, pick the first set `req` searching from `rr+1` modulo `N_REQ`.
  - Load `owner`, set `grant_v`, go to GRANT.
  - If `tx_busy`=1, stay in IDLE; this covers a UART still shifting after a reset.
- GRANT:
  - If `req[owner]`=1: register `tx_data`=`data[owner]`, pulse `tx_req` and `ack[owner]`, latch `last[owner]` into `last_q`, go to WAIT_START.
  - If `req[owner]`=0: hold the lock and stay; other requesters are ignored.
- WAIT_START: wait for `tx_busy`=1, then go to WAIT_END.
- WAIT_END: wait for `tx_busy`=0.
  - If `last_q`=1: set `rr`=`owner`, clear `grant_v`, go to IDLE.
  - Otherwise go back to GRANT; the same owner continues.
- `rr` resets to N_REQ-1, so requester 0 wins first after reset.
- Requester rules:
  - Hold `req`, `data` and `last` stable until the `ack` cycle.
  - `req` may stay high back-to-back; the next byte is taken in the next GRANT visit.
- At most one `ack` bit is high in any cycle, and `tx_req` is high exactly in `ack` cycles.
- Unselected `ack` bits are 0.

## Timing
- Reset values: `ack`=0, `tx_data`=0, `tx_req`=0, `grant_v`=0, `owner`=0, `to_irq`=0, `last_q`=0, state IDLE, `rr`=N_REQ-1.
- Reset asserted mid-packet: return to reset values on the next edge. No `ack` or `tx_req` is issued in that cycle.
- All outputs are registered.
- Latency, with `req` sampled in IDLE at edge k:
  - `grant_v`/`owner` are valid after edge k.
  - `tx_req`/`ack` are high for the single cycle after edge k+1.
  - Minimum from `req` to `tx_req` is 2 cycles.
- Per byte overhead:
  - From `tx_busy` falling (sampled in WAIT_END) to the next `tx_req`: 1 cycle within a packet.
  - Between packets: 2 cycles.
- Simultaneous requests in IDLE: round-robin resolves them; no requester is served twice while another waits.
- Request arriving in the same cycle a lock releases: it competes in the next IDLE evaluation, never in the releasing cycle.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A counter counts consecutive GRANT cycles with `req[owner]`=0.
  - When it reaches `TIMEOUT`: pulse `to_irq`, clear `grant_v`, set `rr`=`owner`, go to IDLE.
  - The counter clears on every `ack` and on entry to GRANT.
- `UART_ARB_TIMEOUT_EN` undefined:
  - The lock is held indefinitely; no counter logic exists.
  - `to_irq` is tied 0.

## Test plan
- Reset, then `req`=4'b0001, `data[7:0]`=8'hA5, `last`=1, with a UART model holding `tx_busy` for 10 cycles.
  - Expect `tx_req` 2 cycles after `req`, `tx_data`=8'hA5, `ack`=4'b0001 for 1 cycle, and `grant_v` low 1 cycle after `tx_busy` falls.
- `req`=4'b1111 continuously, single-byte packets.
  - Expect grant order 0,1,2,3,0, and exactly one `ack` bit per `tx_req`.
- Requester 2 sends 3-byte packet 8'h11/8'h22/8'h33 (`last` on the third) while requester 1 requests.
  - Expect three consecutive `ack[2]`, then `owner`=1; requester 1 gets no `ack` before `last_q` releases.
- `tx_busy`=1 held through reset release with `req`=4'b0010.
  - Expect no grant until `tx_busy`=0, then `owner`=1.
- Assert `rstn`=0 during WAIT_END of a multi-byte packet.
  - Expect all outputs at reset values after the next edge, and grant order restarting from requester 0.
- With `UART_ARB_TIMEOUT_EN` and `TIMEOUT`=16: owner 0 sends a non-last byte and then drops `req`.
  - Expect a `to_irq` pulse after 16 idle GRANT cycles, `grant_v`=0, and requester 3 (pending) granted next.
